// File: rtl/afe_adc_emu.sv
// -----------------------------------------------------------------------------
// afe_adc_emu
//
// Synthesizable stand-in for the ADC side of an AFE. It emits interleaved I/Q
// sample words on a sel-tagged bus, one word per sclk_2x rising edge:
// sel=1 marks an I word and sel=0 marks the Q word of the same pair. The
// emulator is used in bring-up and self-test builds. Its patterns are
// deterministic, so the receive path and FIFO can be checked bit-exactly.
//
// Patterns (mode): 0 RAMP, 1 CONST, 2 PRBS (x^15+x^14+1), 3 COUNT.
//
// Ports:
//   sclk_2x   in   word clock, one I or Q word per rising edge
//   reset     in   asynchronous, active-high reset
//   en        in   stream enable (level); a started pair is always completed
//   restart   in   single-cycle pulse, clears ramp acc / LFSR / pair counter
//   mode      in   pattern select, sampled at the start of each pair
//   step      in   ramp increment per pair
//   const_i   in   I value for CONST mode
//   const_q   in   Q value for CONST mode
//   d         out  registered sample word
//   sel       out  1 = d carries I, 0 = d carries Q
//   pair_cnt  out  number of complete pairs emitted (wraps at 2^32)
//   active    out  1 while a pair stream is being emitted
//
// The LFSR slices assume a word width of at most 15 bits, and the COUNT
// pattern assumes a pair width of at most 32 bits.
// -----------------------------------------------------------------------------
module afe_adc_emu #(
    parameter int unsigned IQ_PAIR_WIDTH = 24,
    parameter logic [14:0] PRBS_SEED     = 15'h0001
) (
    input  logic                         sclk_2x,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         restart,
    input  logic [1:0]                   mode,
    input  logic [IQ_PAIR_WIDTH/2-1:0]   step,
    input  logic [IQ_PAIR_WIDTH/2-1:0]   const_i,
    input  logic [IQ_PAIR_WIDTH/2-1:0]   const_q,
    output logic [IQ_PAIR_WIDTH/2-1:0]   d,
    output logic                         sel,
    output logic [31:0]                  pair_cnt,
    output logic                         active
);

    localparam int unsigned W = IQ_PAIR_WIDTH / 2;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_PRBS  = 2'd2;
    localparam logic [1:0] MODE_COUNT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_I = 2'd1,
        EMIT_Q = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   d_q, d_d;
    logic           sel_q, sel_d;
    logic           active_q, active_d;
    logic [31:0]    pair_cnt_q, pair_cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [14:0]    lfsr_q, lfsr_d;
    logic [W-1:0]   q_lat_q, q_lat_d;

    logic [W-1:0]   gen_i;
    logic [W-1:0]   gen_q;
    logic [14:0]    lfsr_next;

    // Fibonacci step: feedback from taps 15 and 14 enters at bit 0.
    assign lfsr_next = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};

    // Candidate I/Q words for a pair that would start on this edge. They are
    // only used when the FSM loads a new I word.
    always_comb begin
        gen_i = '0;
        gen_q = '0;
        case (mode)
            MODE_RAMP: begin
                gen_i = acc_q;
                gen_q = ~acc_q;
            end
            MODE_CONST: begin
                gen_i = const_i;
                gen_q = const_q;
            end
            MODE_PRBS: begin
                gen_i = lfsr_q[W-1:0];
                gen_q = lfsr_q[14:15-W];
            end
            MODE_COUNT: begin
                gen_i = pair_cnt_q[W-1:0];
                gen_q = pair_cnt_q[2*W-1:W];
            end
            default: begin
                gen_i = '0;
                gen_q = '0;
            end
        endcase
    end

    // Next-state and output logic. A pair starts from IDLE or EMIT_Q when en
    // is high. EMIT_I always finishes the pair, so sel strictly alternates.
    // restart is applied last so that it overrides any advance on the same
    // edge, while the pair being loaded still uses the pre-restart values.
    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        sel_d      = sel_q;
        active_d   = active_q;
        pair_cnt_d = pair_cnt_q;
        acc_d      = acc_q;
        lfsr_d     = lfsr_q;
        q_lat_d    = q_lat_q;

        case (state_q)
            IDLE, EMIT_Q: begin
                if (en) begin
                    state_d  = EMIT_I;
                    d_d      = gen_i;
                    sel_d    = 1'b1;
                    active_d = 1'b1;
                    q_lat_d  = gen_q;
                    if (mode == MODE_RAMP) begin
                        acc_d = acc_q + step;
                    end
                    if (mode == MODE_PRBS) begin
                        lfsr_d = lfsr_next;
                    end
                end else begin
                    state_d  = IDLE;
                    d_d      = '0;
                    sel_d    = 1'b0;
                    active_d = 1'b0;
                end
            end
            EMIT_I: begin
                state_d    = EMIT_Q;
                d_d        = q_lat_q;
                sel_d      = 1'b0;
                active_d   = 1'b1;
                pair_cnt_d = pair_cnt_q + 32'd1;
            end
            default: begin
                state_d  = IDLE;
                d_d      = '0;
                sel_d    = 1'b0;
                active_d = 1'b0;
            end
        endcase

        if (restart) begin
            acc_d      = '0;
            lfsr_d     = PRBS_SEED;
            pair_cnt_d = '0;
        end
    end

    always_ff @(posedge sclk_2x or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            d_q        <= '0;
            sel_q      <= 1'b0;
            active_q   <= 1'b0;
            pair_cnt_q <= '0;
            acc_q      <= '0;
            lfsr_q     <= PRBS_SEED;
            q_lat_q    <= '0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            sel_q      <= sel_d;
            active_q   <= active_d;
            pair_cnt_q <= pair_cnt_d;
            acc_q      <= acc_d;
            lfsr_q     <= lfsr_d;
            q_lat_q    <= q_lat_d;
        end
    end

    assign d        = d_q;
    assign sel      = sel_q;
    assign active   = active_q;
    assign pair_cnt = pair_cnt_q;

endmodule
